// File: rtl/csr_rmw_stage.sv
// csr_rmw_stage: CSR read-modify-write stage with FPU-hazard stall and in-order response FIFO.
// Optional CSR_STALL_PERF_EN adds the perf_csr_stalls counter output.
module csr_rmw_stage #(
  parameter int CORE_ID       = 0,
  parameter int OUT_BUF_SIZE  = 2,
  parameter int UUID_BITS     = 16,
  parameter int NUM_WARPS     = 4,
  parameter int NW_BITS       = 2,
  parameter int NUM_THREADS   = 4,
  parameter int CSR_ADDR_BITS = 12,
  parameter int NR_BITS       = 5
`ifdef CSR_STALL_PERF_EN
  , parameter int PERF_CTR_BITS = 16
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [UUID_BITS-1:0]        req_uuid,
  input  logic [NW_BITS-1:0]          req_wid,
  input  logic [NUM_THREADS-1:0]      req_tmask,
  input  logic [31:0]                 req_pc,
  input  logic [1:0]                  req_op,
  input  logic                        req_use_imm,
  input  logic [4:0]                  req_imm,
  input  logic [31:0]                 req_rs1_data,
  input  logic                        req_rs1_is_zero,
  input  logic [CSR_ADDR_BITS-1:0]    req_addr,
  input  logic [NR_BITS-1:0]          req_rd,
  input  logic                        req_wb,
  input  logic [NUM_WARPS-1:0]        fpu_pending,
  output logic                        csr_read_enable,
  output logic [UUID_BITS-1:0]        csr_read_uuid,
  output logic [CSR_ADDR_BITS-1:0]    csr_read_addr,
  output logic [NW_BITS-1:0]          csr_read_wid,
  input  logic [31:0]                 csr_read_data,
  output logic                        csr_write_enable,
  output logic [UUID_BITS-1:0]        csr_write_uuid,
  output logic [CSR_ADDR_BITS-1:0]    csr_write_addr,
  output logic [NW_BITS-1:0]          csr_write_wid,
  output logic [31:0]                 csr_write_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [UUID_BITS-1:0]        rsp_uuid,
  output logic [NW_BITS-1:0]          rsp_wid,
  output logic [NUM_THREADS-1:0]      rsp_tmask,
  output logic [31:0]                 rsp_pc,
  output logic [NR_BITS-1:0]          rsp_rd,
  output logic                        rsp_wb,
  output logic [NUM_THREADS*32-1:0]   rsp_data,
  output logic                        busy
`ifdef CSR_STALL_PERF_EN
  , output logic [PERF_CTR_BITS-1:0]  perf_csr_stalls
`endif
);
  localparam int PW = $clog2(OUT_BUF_SIZE);
  localparam int EW = UUID_BITS + NW_BITS + NUM_THREADS + 32 + NR_BITS + 1 + 32;
  localparam logic [PW:0] DEPTH = (PW+1)'(OUT_BUF_SIZE);
  localparam logic [CSR_ADDR_BITS-1:0] FFLAGS = CSR_ADDR_BITS'(1);
  localparam logic [CSR_ADDR_BITS-1:0] FRM    = CSR_ADDR_BITS'(2);
  localparam logic [CSR_ADDR_BITS-1:0] FCSR   = CSR_ADDR_BITS'(3);

  if (OUT_BUF_SIZE < 2 || (OUT_BUF_SIZE & (OUT_BUF_SIZE - 1)) != 0 || CORE_ID < 0) begin : g_bad_cfg
    $error("csr_rmw_stage: OUT_BUF_SIZE must be a power of two >= 2 and CORE_ID non-negative");
  end

  logic [EW-1:0] mem [OUT_BUF_SIZE];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          fpu_stall, fire, pop, src_zero;
  logic [31:0]   src, old, head_old;

  assign fpu_stall = (req_addr == FFLAGS || req_addr == FRM || req_addr == FCSR) && fpu_pending[req_wid];
  // Ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
  assign req_ready = reset && !fpu_stall && count != DEPTH;
  assign fire      = req_valid && req_ready;
  assign rsp_valid = count != '0;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = req_valid || rsp_valid;

  assign old      = csr_read_data;
  assign src      = req_use_imm ? {27'd0, req_imm} : req_rs1_data;
  assign src_zero = req_use_imm ? req_imm == 5'd0 : req_rs1_is_zero;

  assign csr_read_enable  = fire;
  assign csr_read_uuid    = req_uuid;
  assign csr_read_addr    = req_addr;
  assign csr_read_wid     = req_wid;
  assign csr_write_enable = fire && (req_op == 2'b01 || (req_op[1] && !src_zero));
  assign csr_write_uuid   = req_uuid;
  assign csr_write_addr   = req_addr;
  assign csr_write_wid    = req_wid;
  assign csr_write_data   = req_op == 2'b01 ? src : req_op == 2'b10 ? (old | src) : (old & ~src);

  assign {rsp_uuid, rsp_wid, rsp_tmask, rsp_pc, rsp_rd, rsp_wb, head_old} = mem[rd_ptr];
  assign rsp_data = {NUM_THREADS{head_old}};

  always_ff @(posedge clk) begin
    if (fire) mem[wr_ptr] <= {req_uuid, req_wid, req_tmask, req_pc, req_rd, req_wb, old};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= fire ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= (fire && !pop) ? count + 1'b1 : (pop && !fire) ? count - 1'b1 : count;
    end
  end

`ifdef CSR_STALL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_csr_stalls <= '0;
    else if (req_valid && !req_ready) perf_csr_stalls <= perf_csr_stalls + 1'b1;
  end
`endif
endmodule
